rggen_bit_field_rw_keyed: RTL
=============================

// Module: rggen_bit_field_rw_keyed
// PURPOSE
//  Key-protected RW bit field, successor to the single-signal lock/enable field.
//  - Adds a key-sequence unlock state machine, an unlock window timer and optional one-shot relock.
//  - Keeps the external lock/enable gate, generalised over MODE.
//  - Instantiated per field inside a register block; attaches to rggen_bit_field_if.
// PARAMETERS
//  MODE           RGGEN_LOCK_MODE  external gate polarity; gate open when i_lock_or_enable == MODE
//  WIDTH          8                field width in bits, >= 1
//  INITIAL_VALUE  '0               WIDTH-bit reset value of the field
//  KEY_DEPTH      2                number of key words in the unlock sequence, >= 1
//  KEY_VALUE      '0               KEY_DEPTH*WIDTH bits; key k = KEY_VALUE[k*WIDTH+:WIDTH], key 0 first
//  TIMEOUT        16               cycle budget for key sequence and for unlock window, >= 1
//  ONE_SHOT       1                1: relock after first accepted data write; 0: stay unlocked until timeout
// PORTS
//  clk               input   1      clock, all state on posedge
//  rst               input   1      synchronous reset, active-high
//  i_lock_or_enable  input   1      external lock/enable gate
//  bit_field_if      slave   -      rggen_bit_field_if: write_access, write_data, write_mask -> value, read_data
//  o_value           output  WIDTH  current field value
//  o_unlocked        output  1      (RGGEN_KEYED_FIELD_STATUS_EN only) 1 while state == UNLOCKED
//  o_key_error       output  1      (RGGEN_KEYED_FIELD_STATUS_EN only) 1-cycle pulse on a bad key write
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - value=INITIAL_VALUE, state=LOCKED, key_idx=0, timer=0.
//   - o_unlocked=0, o_key_error=0.
//  Combinational outputs
//   - o_value = bit_field_if.value = bit_field_if.read_data = value, every cycle, in all states.
//  Gate
//   - gate_open = (i_lock_or_enable == MODE).
//   - Any write while gate closed: no effect on value, state or key_idx; timer still counts.
//  States: LOCKED, ARMING, UNLOCKED
//   - key write = write_access & (write_mask == all ones) & gate_open.
//   - A write with a partial mask never matches a key.
//  LOCKED / ARMING
//   - value never changes.
//   - Key write with data == KEY[key_idx]: key_idx++.
//     - Not last key: state=ARMING, timer=TIMEOUT (loaded on first key only).
//     - Last key (key_idx == KEY_DEPTH-1): state=UNLOCKED, key_idx=0, timer=TIMEOUT.
//     - KEY_DEPTH=1: a single matching write goes LOCKED->UNLOCKED.
//   - Any other gated write (wrong data or partial mask) in LOCKED/ARMING: key error.
//     - If data == KEY[0] and mask is full: key_idx=1, state=ARMING, timer=TIMEOUT.
//     - Else: key_idx=0, state=LOCKED.
//   - ARMING timer decrements each cycle without a matching key.
//     - timer==1 with no matching write: next state LOCKED, key_idx=0, no error.
//  UNLOCKED
//   - Gated write_access: value <= (value & ~mask) | (data & mask), visible next cycle.
//   - ONE_SHOT=1: the same edge sets state=LOCKED.
//   - Timer decrements each cycle; timer==1 -> next state LOCKED.
//   - Write in the timer==1 cycle is still accepted.
//   - Ungated or absent writes leave value unchanged.
//  Latency and sizing
//   - All transitions take effect at the next posedge; no stalls, no backpressure.
//   - Timer width $clog2(TIMEOUT+1); key_idx width $clog2(KEY_DEPTH) (min 1); no wrap.
//  Reset mid-sequence or mid-window
//   - Returns to LOCKED; value reverts to INITIAL_VALUE.
// CONFIGURATION
//  Macro RGGEN_KEYED_FIELD_STATUS_EN
//   - Defined: o_unlocked and o_key_error ports exist.
//     - o_key_error is registered: asserts the cycle after the bad key write.
//   - Undefined: neither port exists; field behaviour otherwise identical.
// TESTING
//  1. WIDTH=8, KEY={8'hA5,8'h5A}; write A5 then 5A (full mask), then write 3C -> value=3C; 4th write 77 ignored (ONE_SHOT=1).
//  2. Locked, write 3C full mask -> value unchanged (INITIAL_VALUE); o_key_error=1 for one cycle.
//  3. Write A5 then 00 then A5, 5A -> 00 resets progress, second A5 restarts, then unlocked; write F0 -> value=F0.
//  4. TIMEOUT=4: unlock, idle 4 cycles, write 11 -> value unchanged; state LOCKED, o_unlocked=0.
//  5. ONE_SHOT=0, unlocked: write 0F mask 0F then F0 mask F0 in window -> value=FF; write in timer==1 cycle accepted.
//  6. MODE=LOCK, i_lock_or_enable=1 during key writes -> no unlock; assert rst while UNLOCKED -> value=INITIAL_VALUE, LOCKED.

Source files
------------

// File: rtl/rggen_bit_field_rw_keyed_if.sv
// Register-block side of a single bit field: write strobe/data/mask in, field value out.
interface rggen_bit_field_if #(
    parameter int WIDTH = 8
);
    logic             write_access;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] write_mask;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] read_data;

    modport master (
        output write_access, write_data, write_mask,
        input  value, read_data
    );

    modport slave (
        input  write_access, write_data, write_mask,
        output value, read_data
    );
endinterface

// File: rtl/rggen_bit_field_rw_keyed.sv
// Key-protected RW bit field: a key word sequence opens a timed write window, optionally one-shot.
// Optional status ports o_unlocked / o_key_error exist only when RGGEN_KEYED_FIELD_STATUS_EN is defined.
module rggen_bit_field_rw_keyed #(
    parameter bit                        MODE          = 1'b0,
    parameter int                        WIDTH         = 8,
    parameter logic [WIDTH-1:0]          INITIAL_VALUE = '0,
    parameter int                        KEY_DEPTH     = 2,
    parameter logic [KEY_DEPTH*WIDTH-1:0] KEY_VALUE    = '0,
    parameter int                        TIMEOUT       = 16,
    parameter int                        ONE_SHOT      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_lock_or_enable,
    rggen_bit_field_if.slave     bit_field_if,
    output logic [WIDTH-1:0]     o_value
`ifdef RGGEN_KEYED_FIELD_STATUS_EN
   ,output logic                 o_unlocked
   ,output logic                 o_key_error
`endif
);
    localparam int KIW = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        LOCKED,
        ARMING,
        UNLOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [KIW-1:0]   key_idx_q, key_idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] value_q, value_d;

    logic             gated_write;
    logic             full_mask;
    logic             key_match;
    logic             last_key;
    logic [WIDTH-1:0] cur_key;

    assign gated_write = bit_field_if.write_access && (i_lock_or_enable == MODE);
    assign full_mask   = (bit_field_if.write_mask == '1);
    assign last_key    = (int'(key_idx_q) == KEY_DEPTH - 1);
    assign key_match   = gated_write && full_mask && (bit_field_if.write_data == cur_key);

    always_comb begin
        cur_key = KEY_VALUE[WIDTH-1:0];
        for (int k = 0; k < KEY_DEPTH; k++) begin
            if (int'(key_idx_q) == k) begin
                cur_key = KEY_VALUE[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        key_idx_d = key_idx_q;
        timer_d   = timer_q;
        value_d   = value_q;
        case (state_q)
            LOCKED, ARMING: begin
                if (key_match) begin
                    if (last_key) begin
                        state_d   = UNLOCKED;
                        key_idx_d = '0;
                        timer_d   = TW'(TIMEOUT);
                    end else begin
                        state_d   = ARMING;
                        key_idx_d = key_idx_q + KIW'(1);
                        if (state_q == LOCKED) begin
                            timer_d = TW'(TIMEOUT);
                        end
                    end
                end else if (gated_write) begin
                    // A bad word that happens to be the first key restarts the sequence
                    if (full_mask && (bit_field_if.write_data == KEY_VALUE[WIDTH-1:0])) begin
                        state_d   = ARMING;
                        key_idx_d = KIW'(1);
                        timer_d   = TW'(TIMEOUT);
                    end else begin
                        state_d   = LOCKED;
                        key_idx_d = '0;
                        timer_d   = '0;
                    end
                end else if (state_q == ARMING) begin
                    if (timer_q == TW'(1)) begin
                        state_d   = LOCKED;
                        key_idx_d = '0;
                        timer_d   = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            UNLOCKED: begin
                if (gated_write) begin
                    value_d = (value_q & ~bit_field_if.write_mask)
                            | (bit_field_if.write_data & bit_field_if.write_mask);
                end
                if ((timer_q == TW'(1)) || ((ONE_SHOT != 0) && gated_write)) begin
                    state_d = LOCKED;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d   = LOCKED;
                key_idx_d = '0;
                timer_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOCKED;
            key_idx_q <= '0;
            timer_q   <= '0;
            value_q   <= INITIAL_VALUE;
        end else begin
            state_q   <= state_d;
            key_idx_q <= key_idx_d;
            timer_q   <= timer_d;
            value_q   <= value_d;
        end
    end

    assign o_value                = value_q;
    assign bit_field_if.value     = value_q;
    assign bit_field_if.read_data = value_q;

`ifdef RGGEN_KEYED_FIELD_STATUS_EN
    logic key_error_q, key_error_d;

    // Flags any gated write in LOCKED/ARMING that is not the expected key word
    assign key_error_d = gated_write && !key_match && (state_q != UNLOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_error_q <= 1'b0;
        end else begin
            key_error_q <= key_error_d;
        end
    end

    assign o_unlocked  = (state_q == UNLOCKED);
    assign o_key_error = key_error_q;
`else
    // Status stays internal; field behaviour is unchanged.
`endif
endmodule
